// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage PC owner issuing imem reads into a small fetch FIFO
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic        fetchValid,
    output logic [31:0] PCPlus4IF,
    output logic [31:0] instructionIF
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d, addr_q;
    logic          req_q;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_q, wr_q;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];
    logic          consume, push;
    assign fetchValid    = count_q != '0;
    assign consume       = fetchValid & ~stall & ~redirect;
    assign push          = (state_q == BUSY) & imemReady & ~redirect;
    assign imemReq       = req_q;
    assign imemAddr      = addr_q;
    assign PCPlus4IF     = fetchValid ? pc_mem_q[rd_q] + 32'd4 : '0;
    assign instructionIF = fetchValid ? ins_mem_q[rd_q] : '0;
    assign count_d = redirect ? '0 : count_q + (AW+1)'(push) - (AW+1)'(consume);
    assign pc_d    = redirect ? (redirectPC & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
    // Next state: a request caught by a redirect before completing must still be drained
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (redirect || count_q < FULL) ? BUSY : IDLE;
            BUSY:    state_d = redirect ? (imemReady ? IDLE : DRAIN)
                                        : (imemReady && count_d >= FULL) ? IDLE : BUSY;
            DRAIN:   state_d = imemReady ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // Control state; the address freezes while draining so the aborted read stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= (state_d == DRAIN) ? addr_q : pc_d;
            req_q   <= state_d != IDLE;
            count_q <= count_d;
            rd_q    <= redirect ? '0 : rd_q + AW'(consume);
            wr_q    <= redirect ? '0 : wr_q + AW'(push);
        end
    end
    // Fetch buffer storage, written with the PC of the completed request
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_q]  <= pc_q;
            ins_mem_q[wr_q] <= imemRdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue model
module tb_fetch_unit;
    localparam int DEPTH = 2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemRdata;
    logic        fetchValid;
    logic [31:0] PCPlus4IF;
    logic [31:0] instructionIF;
    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [31:0] q[$];
    logic [31:0] fetch_pc = '0;
    logic        stale = 1'b0;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirectPC(redirectPC), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemReady(imemReady), .imemRdata(imemRdata), .fetchValid(fetchValid),
        .PCPlus4IF(PCPlus4IF), .instructionIF(instructionIF)
    );

    always #5 clk = ~clk;
    assign imemRdata = imemAddr + 32'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        stale = 1'b0;
        fetch_pc = '0;
    endtask

    // One clock: drive at negedge, advance the queue model, check after the edge
    task automatic drive(input logic st, input logic rdy, input logic rdr, input logic [31:0] rpc);
        logic        pend;
        logic [31:0] paddr;
        stall = st;
        imemReady = rdy;
        redirect = rdr;
        redirectPC = rpc;
        pend = imemReq && !imemReady;
        paddr = imemAddr;
        if (imemReq && !stale) chk("req_addr", imemAddr, fetch_pc);
        if (redirect) begin
            q.delete();
            stale = imemReq && !imemReady;
            fetch_pc = redirectPC & ~32'd3;
        end else begin
            if (q.size() != 0 && !stall) begin
                q.delete(0);
                pops++;
            end
            if (imemReq && imemReady) begin
                if (stale) stale = 1'b0;
                else begin
                    q.push_back(fetch_pc);
                    fetch_pc += 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (pend) begin
            chk("hold_req", 32'(imemReq), 32'd1);
            chk("hold_addr", imemAddr, paddr);
        end
        chk("valid", 32'(fetchValid), 32'(q.size() != 0));
        chk("instr", instructionIF, q.size() != 0 ? q[0] + 32'd1 : 32'd0);
        chk("pc4", PCPlus4IF, q.size() != 0 ? q[0] + 32'd4 : 32'd0);
        if (q.size() == DEPTH) chk("full_noreq", 32'(imemReq), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_addr", imemAddr, 32'd0);
        chk("rst_instr", instructionIF, 32'd0);
        chk("rst_valid", 32'(fetchValid), 32'd0);
        chk("rst_pc4", PCPlus4IF, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_req0", 32'(imemReq), 32'd0);
        drive(0, 0, 0, 0);
        chk("rel_req1", 32'(imemReq), 32'd1);
        chk("rel_addr", imemAddr, 32'd0);
        drive(0, 1, 0, 0);
        chk("zw_i0", instructionIF, 32'd1);
        chk("zw_p0", PCPlus4IF, 32'd4);
        drive(0, 1, 0, 0);
        chk("zw_i1", instructionIF, 32'd5);
        chk("zw_p1", PCPlus4IF, 32'd8);
        drive(0, 1, 0, 0);
        chk("zw_i2", instructionIF, 32'd9);
        chk("zw_p2", PCPlus4IF, 32'd12);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);
        chk("stall_req", 32'(imemReq), 32'd0);
        chk("stall_head", instructionIF, 32'd9);
        drive(0, 1, 0, 0);
        chk("stall_next", instructionIF, 32'd13);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
        chk("fill_req", 32'(imemReq), 32'd0);
        drive(1, 0, 1, 32'h8);
        chk("r8_addr", imemAddr, 32'h8);
        chk("r8_valid", 32'(fetchValid), 32'd0);
        drive(0, 0, 1, 32'h40);
        chk("drain_addr0", imemAddr, 32'h8);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("drain_addr2", imemAddr, 32'h8);
        chk("drain_req", 32'(imemReq), 32'd1);
        drive(0, 1, 0, 0);
        chk("drain_valid", 32'(fetchValid), 32'd0);
        drive(0, 0, 0, 0);
        chk("r40_addr", imemAddr, 32'h40);
        drive(0, 1, 0, 0);
        chk("r40_instr", instructionIF, 32'h41);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
        chk("full_valid", 32'(fetchValid), 32'd1);
        drive(1, 0, 1, 32'h83);
        chk("r83_valid", 32'(fetchValid), 32'd0);
        chk("r83_addr", imemAddr, 32'h80);
        drive(0, 1, 0, 0);
        chk("r83_pc4", PCPlus4IF, 32'h84);
        drive(0, 1, 1, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0);
        chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0);
        chk("wrap_pc4", PCPlus4IF, 32'h0);
        chk("wrap_instr", instructionIF, 32'hFFFF_FFFD);
        drive(0, 1, 0, 0);
        chk("wrap_next", instructionIF, 32'h1);
        drive(0, 0, 1, 32'h100);
        chk("dr_req", 32'(imemReq), 32'd1);
        chk("dr_addr", imemAddr, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imemReq), 32'd0);
        chk("arst_addr", imemAddr, 32'h0);
        chk("arst_valid", 32'(fetchValid), 32'd0);
        model_reset();
        @(negedge clk);
        stall = 1'b0;
        imemReady = 1'b0;
        redirect = 1'b0;
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        chk("arst_pc", imemAddr, 32'h0);
        pops = 0;
        for (int i = 0; i < 500; i++)
            drive($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0, $urandom);
        chk("throughput", 32'(pops >= 20), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
